// File: rtl/per_pkg.sv
// Shared types, widths and the Q7.9 saturation helper for the perceptron inference block.
package per_pkg;
    localparam int Q_FRAC = 9;
    localparam int D_W    = 16;
    localparam int P_W    = 32;
    localparam int S_W    = 34;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD0,
        ST_LD1,
        ST_LD2,
        ST_LD3,
        ST_RUN,
        ST_DONE
    } state_t;

    // Drop the 9 product-only fraction bits, then clamp to the Q7.9 range.
    function automatic logic [D_W-1:0] sat16(input logic signed [S_W-1:0] s);
        logic signed [S_W-1:0] q;
        q = s >>> Q_FRAC;
        if (q > 34'sd32767)
            return 16'h7fff;
        else if (q < -34'sd32768)
            return 16'h8000;
        else
            return q[D_W-1:0];
    endfunction
endpackage

// File: rtl/per_mac_dp.sv
// Two-stage multiply/accumulate/classify pipe; every register advances only on adv.
module per_mac_dp
    import per_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           adv,
    input  logic           s_fire,
    input  logic [D_W-1:0] w1,
    input  logic [D_W-1:0] w2,
    input  logic [D_W-1:0] b,
    input  logic [D_W-1:0] x1,
    input  logic [D_W-1:0] x2,
    input  logic [D_W-1:0] label,
    output logic           m_valid,
    output logic           m_class,
    output logic [D_W-1:0] m_score,
    output logic           m_err
);
    logic                  v1;
    logic                  lbl;
    logic signed [P_W-1:0] p1;
    logic signed [P_W-1:0] p2;
    logic signed [S_W-1:0] sum;

    // Bias is Q7.9; shift it onto the Q14.18 product grid before adding.
    assign sum = S_W'(p1) + S_W'(p2) + (S_W'($signed(b)) <<< Q_FRAC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1      <= 1'b0;
            lbl     <= 1'b0;
            p1      <= '0;
            p2      <= '0;
            m_valid <= 1'b0;
            m_class <= 1'b0;
            m_score <= '0;
            m_err   <= 1'b0;
        end else if (adv) begin
            v1      <= s_fire;
            m_valid <= v1;
            if (s_fire) begin
                p1  <= P_W'($signed(w1)) * P_W'($signed(x1));
                p2  <= P_W'($signed(w2)) * P_W'($signed(x2));
                lbl <= |label;
            end
            if (v1) begin
                m_class <= ~sum[S_W-1];
                m_score <= sat16(sum);
                m_err   <= ~sum[S_W-1] ^ lbl;
            end
        end
    end
endmodule

// File: rtl/per_infer.sv
// Perceptron inference controller: loads trained weights, streams samples, counts errors.
// state | meaning
// IDLE  | waiting for start
// LD0   | read address of w1 issued
// LD1   | capture w1, read w2
// LD2   | capture w2, read b
// LD3   | capture b
// RUN   | streaming samples through the pipe
// DONE  | one-cycle end-of-run pulse
module per_infer
    import per_pkg::*;
#(
    parameter logic [6:0] W_BASE = 7'd1,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [10:0]      n_samples,
    output logic             w_ena,
    output logic [6:0]       w_addr,
    input  logic [D_W-1:0]   w_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [D_W-1:0]   s_x1,
    input  logic [D_W-1:0]   s_x2,
    input  logic [D_W-1:0]   s_label,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_class,
    output logic [D_W-1:0]   m_score,
    output logic             m_err,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy,
    output logic             done
);
    state_t         state;
    state_t         state_nx;
    logic [D_W-1:0] w1;
    logic [D_W-1:0] w2;
    logic [D_W-1:0] b;
    logic [10:0]    n_lat;
    logic [10:0]    acc_cnt;
    logic           adv;
    logic           fire;
    logic           hs;
    logic           last_hs;

    assign adv     = ~m_valid | m_ready;
    assign s_ready = (state == ST_RUN) & adv & (acc_cnt < n_lat);
    assign fire    = s_valid & s_ready;
    assign hs      = m_valid & m_ready;
    assign last_hs = hs & (smp_cnt == CNT_W'(n_lat) - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_LD0;
            ST_LD0:  state_nx = ST_LD1;
            ST_LD1:  state_nx = ST_LD2;
            ST_LD2:  state_nx = ST_LD3;
            ST_LD3:  state_nx = (n_lat == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (last_hs) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ena  = 1'b0;
        w_addr = '0;
        case (state)
            ST_LD0: begin w_ena = 1'b1; w_addr = W_BASE;         end
            ST_LD1: begin w_ena = 1'b1; w_addr = W_BASE + 7'd1;  end
            ST_LD2: begin w_ena = 1'b1; w_addr = W_BASE + 7'd2;  end
            default: ;
        endcase
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Read data lags the address by one cycle, so each capture sits one state later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w1 <= '0;
            w2 <= '0;
            b  <= '0;
        end else begin
            if (state == ST_LD1) w1 <= w_data;
            if (state == ST_LD2) w2 <= w_data;
            if (state == ST_LD3) b  <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_lat   <= '0;
            acc_cnt <= '0;
            smp_cnt <= '0;
            err_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            n_lat   <= n_samples;
            acc_cnt <= '0;
            smp_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (fire) acc_cnt <= acc_cnt + 11'd1;
            if (hs)   smp_cnt <= smp_cnt + CNT_W'(1);
            if (hs && m_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    per_mac_dp u_dp (
        .clk     (clk),
        .rst     (rst),
        .adv     (adv),
        .s_fire  (fire),
        .w1      (w1),
        .w2      (w2),
        .b       (b),
        .x1      (s_x1),
        .x2      (s_x2),
        .label   (s_label),
        .m_valid (m_valid),
        .m_class (m_class),
        .m_score (m_score),
        .m_err   (m_err)
    );
endmodule

// File: tb/tb_per_infer.sv
// Scoreboard bench for per_infer: arithmetic reference model, decoupled result monitor.
module tb_per_infer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [10:0] n_samples = '0;
    logic        w_ena;
    logic [6:0]  w_addr;
    logic [15:0] w_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_x1 = '0, s_x2 = '0, s_label = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_class;
    logic [15:0] m_score;
    logic        m_err;
    logic [15:0] smp_cnt, err_cnt;
    logic        busy, done;

    per_infer dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_x1(s_x1), .s_x2(s_x2), .s_label(s_label),
        .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_score(m_score), .m_err(m_err),
        .smp_cnt(smp_cnt), .err_cnt(err_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        cls;
        logic [15:0] score;
        logic        err;
    } res_t;

    logic [15:0] mem [0:127];
    res_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          err_exp = 0;
    int          cyc = 0;
    int          stall_from = -100;
    bit          rand_bp = 1'b0;
    logic [15:0] cw1, cw2, cb;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_ena) w_data <= mem[w_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Real-valued perceptron: w.x + b in units of 2^-18, floor back to Q7.9, clamp.
    function automatic res_t model(input logic [15:0] w1, w2, b, x1, x2, lbl);
        longint s, q;
        res_t   r;
        s = longint'($signed(w1)) * longint'($signed(x1))
          + longint'($signed(w2)) * longint'($signed(x2))
          + longint'($signed(b)) * 512;
        q = (s >= 0) ? s / 512 : -((-s + 511) / 512);
        if (q > 32767) q = 32767;
        else if (q < -32768) q = -32768;
        r.cls   = (s >= 0);
        r.score = q[15:0];
        r.err   = r.cls ^ (lbl != 16'h0);
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = !(cyc >= stall_from && cyc < stall_from + 5) &&
                      (!rand_bp || ($urandom_range(0, 3) != 0));
        end
    end

    // Result monitor
    initial begin : monitor
        bit   hold_prev;
        res_t held;
        res_t e;
        hold_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (hold_prev)
                    check("hold", {m_valid, m_class, m_score, m_err}, {1'b1, held});
                if (m_valid && !m_ready)
                    check("s_ready_stall", 32'(s_ready), 32'd0);
                hold_prev = m_valid && !m_ready;
                held = {m_class, m_score, m_err};
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got %h expected none", {m_class, m_score, m_err});
                    end else begin
                        e = sb.pop_front();
                        check("result", 32'({m_class, m_score, m_err}), 32'(e));
                    end
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic pulse_start(input logic [10:0] n);
        n_samples = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_start(input logic [10:0] n, input logic [15:0] w1, w2, b);
        mem[1] = w1; mem[2] = w2; mem[3] = b;
        cw1 = w1; cw2 = w2; cb = b;
        err_exp = 0;
        pulse_start(n);
    endtask

    task automatic send(input logic [15:0] x1, x2, lbl);
        bit   ok;
        res_t r;
        ok = 1'b0;
        s_valid = 1'b1; s_x1 = x1; s_x2 = x2; s_label = lbl;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                r = model(cw1, cw2, cb, x1, x2, lbl);
                sb.push_back(r);
                if (r.err) err_exp++;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int n_exp);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        check("done_seen", 32'(ok), 32'd1);
        check("smp_cnt", 32'(smp_cnt), 32'(n_exp));
        check("err_cnt", 32'(err_cnt), 32'(err_exp));
        check("sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_lbl();
        return ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  lat;
        bit  rdy_seen;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        #1;
        check("rst_outputs", {busy, done, m_valid, m_class, m_err, s_ready, w_ena},  7'b0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_m_score", 32'(m_score), 32'd0);
        check("rst_cnts", {smp_cnt, err_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Test 1: basic classify and load-to-RUN latency
        do_start(11'd1, 16'h0200, 16'h0200, 16'hfe00);
        lat = -1;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (s_ready) lat = k;
        end
        check("run_latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
        send(16'h0200, 16'h0000, 16'h0200);
        wait_done(1);

        // Test 2: negative sum, then a mismatch
        do_start(11'd2, 16'h0200, 16'h0200, 16'hfe00);
        send(16'h0000, 16'h0000, 16'h0000);
        send(16'h0000, 16'h0000, 16'h0200);
        wait_done(2);

        // Test 3: saturation at both ends
        do_start(11'd1, 16'h7fff, 16'h7fff, 16'h7fff);
        send(16'h7fff, 16'h7fff, 16'h0001);
        wait_done(1);
        do_start(11'd1, 16'h7fff, 16'h7fff, 16'h8000);
        send(16'h7fff, 16'h8001, 16'h0000);
        wait_done(1);

        // Test 4: 5-cycle stall mid-stream
        do_start(11'd8, 16'($urandom), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 8; i++) begin
            if (i == 2) stall_from = cyc + 1;
            send(16'($urandom), 16'($urandom), rnd_lbl());
        end
        wait_done(8);

        // Test 5: empty run, and start ignored while busy
        do_start(11'd0, 16'h1234, 16'h5678, 16'h9abc);
        lat = -1;
        rdy_seen = 1'b0;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (s_ready) rdy_seen = 1'b1;
            if (done) lat = k;
        end
        check("nzero_done_lat", 32'(lat), 32'd4);
        check("nzero_no_ready", 32'(rdy_seen), 32'd0);
        @(posedge clk); #1;
        do_start(11'd3, 16'h0100, 16'hff00, 16'h0010);
        send(16'h0400, 16'h0200, 16'h0000);
        pulse_start(11'd5);
        check("start_ignored_busy", 32'(busy), 32'd1);
        send(16'hfc00, 16'h0100, 16'h0001);
        send(16'h0000, 16'h0300, 16'h0001);
        wait_done(3);

        // Test 6: async reset at the 3rd accepted sample, then a clean rerun
        do_start(11'd8, 16'h0300, 16'hfd00, 16'h0040);
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), rnd_lbl());
        rst = 1'b0;
        #1;
        check("mid_rst_state", {busy, m_valid}, 2'b00);
        check("mid_rst_cnts", {smp_cnt, err_cnt}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_start(11'd4, 16'hff80, 16'h0280, 16'hff00);
        for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), rnd_lbl());
        wait_done(4);

        // Random runs with random backpressure
        rand_bp = 1'b1;
        for (int r = 0; r < 3; r++) begin
            do_start(11'd12, 16'($urandom), 16'($urandom), 16'($urandom));
            for (int i = 0; i < 12; i++) send(16'($urandom), 16'($urandom), rnd_lbl());
            wait_done(12);
        end
        rand_bp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
